addr_burst_sched: RTL
=====================

# addr_burst_sched

Write-clock-domain scheduler in front of the AXI-to-AHB address FIFO. Arbitrates the AXI write-address (AW) and read-address (AR) channels round-robin, accepts one burst at a time, expands it into per-beat 32-bit addresses (FIXED/INCR/WRAP), and pushes one address per cycle into the FIFO write port. It also drives direction/last sidebands into the companion tag FIFO. It honours FIFO `full` and never pushes into a full FIFO.

## Interface
- `ADDR_W`, 32, address width; equals FIFO data width.
- `LEN_W`, 8, AXI burst length width; beats = len+1.
- `BUS_BYTES_LOG2`, 2, log2 of AHB data bus bytes; maximum legal size.
- `wclk` in 1: single clock, the FIFO write clock.
- `reset` in 1: synchronous, active-high.
- `awvalid` in 1 / `awready` out 1: AW handshake.
- `awaddr` in ADDR_W, `awlen` in LEN_W, `awsize` in 3, `awburst` in 2: AW burst attributes.
- `arvalid` in 1 / `arready` out 1: AR handshake.
- `araddr` in ADDR_W, `arlen` in LEN_W, `arsize` in 3, `arburst` in 2: AR burst attributes.
- `fifo_full` in 1: addr FIFO full flag (write side).
- `fifo_write_en` out 1: push strobe.
- `fifo_data` out ADDR_W: beat address.
- `tag_dir` out 1: 1 = write burst, 0 = read; valid with `fifo_write_en`.
- `tag_last` out 1: final beat of burst; valid with `fifo_write_en`.
- `burst_err` out 1: one-cycle pulse on acceptance of an illegal burst.
- `busy` out 1: high while in BURST.

## Operation
- FSM: IDLE, BURST.
- **IDLE**
  - Grant = AW if only awvalid; AR if only arvalid.
  - If both are valid, grant the channel not granted last (`last_grant` reg, 1 = AW).
  - Granted ready is asserted combinationally; handshake completes in that cycle.
  - On handshake, latch addr/len/size/burst/dir, load `beat_cnt` = len, update `last_grant`, go to BURST.
- **BURST**
  - `fifo_write_en` = !fifo_full; `fifo_data` = current address.
  - `tag_last` = (beat_cnt == 0); `tag_dir` = latched dir.
  - On each push: decrement beat_cnt and advance the address. If it was the last beat, go to IDLE.
  - When fifo_full is high: hold all state; no push.
- **Address step:** incr = 1 << size.
  - FIXED (2'b00): address unchanged.
  - INCR (2'b01): addr + incr, modulo 2^ADDR_W.
  - WRAP (2'b10): mask = ((len+1) << size) − 1; next = (addr & ~mask) | ((addr + incr) & mask).
- **Illegal bursts:** `burst_err` pulses in the cycle after handshake.
  - burst 2'b11 → treated as INCR.
  - WRAP with len ∉ {1,3,7,15} → treated as INCR.
  - size > BUS_BYTES_LOG2 → size clamped to BUS_BYTES_LOG2.
- 4 KB boundary crossing is not checked.

## Timing
- Reset (while `reset` high, and the cycle after):
  - state IDLE, beat_cnt 0, `last_grant` 0, so the first AW/AR tie goes to AW.
  - awready, arready, fifo_write_en, tag_dir, tag_last, burst_err, busy are all 0; fifo_data 0.
  - Ready outputs are forced low while `reset` is high.
- Reset mid-burst: the burst is abandoned and remaining beats are not pushed; FIFO contents are the FIFO's concern.
- Latency: handshake in cycle N → first push no earlier than N+1.
- Throughput: one beat per cycle when not full. One dead cycle (IDLE) between consecutive bursts.
- Ready is never asserted outside IDLE, and never asserted to both channels in one cycle.
- fifo_full is sampled combinationally each cycle. The FIFO's pessimistic (synchronised-pointer) full only stalls, never corrupts.
- len = 0: single push, tag_last = 1, return to IDLE the next cycle.

## Structure
- Package `axi2ahb_pkg`:
  - burst encodings BURST_FIXED/INCR/WRAP
  - FSM state enum
  - the legal wrap-length set
- Sub-module `addr_next_calc`: combinational next-address from addr/size/len/burst, including wrap masking. This unit is tested separately.
- `burst_err` and size clamp logic live in the top level.

## Test plan
- AW INCR addr 0x1000, len 3, size 2, FIFO never full → pushes 0x1000, 0x1004, 0x1008, 0x100C on 4 consecutive cycles; tag_dir 1; tag_last only on 0x100C.
- AR WRAP addr 0x2038, len 3, size 3 → pushes 0x2038, then wraps to 0x2020, 0x2028, 0x2030; burst_err 0.
- awvalid and arvalid held high from reset, each len 0 → grants alternate AW, AR, AW, AR; one push per two cycles.
- INCR len 7 with fifo_full asserted for 3 cycles after beat 2 → no push while full; beats 3–7 resume with correct addresses; no beat lost or duplicated.
- WRAP len 2, and separately size 3 with BUS_BYTES_LOG2 = 2 → burst_err pulses once; first case handled as INCR, second uses increment 4.
- reset asserted mid-burst after 2 of 8 beats → outputs 0 next cycle; new AR accepted after reset deasserts, starting at its own address.

Source files
------------

// File: rtl/axi2ahb_pkg.sv
// rtl/axi2ahb_pkg.sv - shared types and constants for the AXI-to-AHB address path
package axi2ahb_pkg;

  localparam int ADDR_W_DEF         = 32;
  localparam int LEN_W_DEF          = 8;
  localparam int BUS_BYTES_LOG2_DEF = 2;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  // Only these AXI lengths describe a power-of-two wrap container.
  function automatic logic is_wrap_len(input int unsigned len);
    return (len == 1) || (len == 3) || (len == 7) || (len == 15);
  endfunction

endpackage

// File: rtl/addr_burst_sched_if.sv
// rtl/addr_burst_sched_if.sv - AXI AW/AR address channels plus address/tag FIFO write side
interface addr_burst_sched_if
  import axi2ahb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
);
  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic [LEN_W-1:0]  awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [LEN_W-1:0]  arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              fifo_full;
  logic              fifo_write_en;
  logic [ADDR_W-1:0] fifo_data;
  logic              tag_dir;
  logic              tag_last;
  logic              burst_err;
  logic              busy;

  modport master (
    output awvalid, awaddr, awlen, awsize, awburst,
    output arvalid, araddr, arlen, arsize, arburst,
    output fifo_full,
    input  awready, arready, fifo_write_en, fifo_data, tag_dir, tag_last, burst_err, busy
  );

  modport slave (
    input  awvalid, awaddr, awlen, awsize, awburst,
    input  arvalid, araddr, arlen, arsize, arburst,
    input  fifo_full,
    output awready, arready, fifo_write_en, fifo_data, tag_dir, tag_last, burst_err, busy
  );

endinterface

// File: rtl/addr_next_calc.sv
// rtl/addr_next_calc.sv - combinational next beat address for FIXED/INCR/WRAP bursts
module addr_next_calc
  import axi2ahb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  input  logic [LEN_W-1:0]  len,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr
);
  logic [ADDR_W-1:0] incr;
  logic [ADDR_W-1:0] sum;
  logic [ADDR_W-1:0] mask;

  always_comb begin
    incr = ADDR_W'(1) << size;
    sum  = addr + incr;
    // Wrap container is the whole burst in bytes; only the low bits roll over.
    mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~mask) | (sum & mask);
      default:     next_addr = sum;
    endcase
  end

endmodule

// File: rtl/addr_burst_sched.sv
// rtl/addr_burst_sched.sv - round-robin AW/AR burst scheduler feeding the address FIFO
module addr_burst_sched
  import axi2ahb_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int LEN_W          = LEN_W_DEF,
  parameter int BUS_BYTES_LOG2 = BUS_BYTES_LOG2_DEF
) (
  input  logic              wclk,
  input  logic              reset,
  addr_burst_sched_if.slave bus
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, next_addr;
  logic [LEN_W-1:0]  len_q, len_d, beat_cnt_q, beat_cnt_d;
  logic [2:0]        size_q, size_d;
  logic [1:0]        burst_q, burst_d;
  logic              dir_q, dir_d;
  logic              last_grant_q, last_grant_d;
  logic              burst_err_q, burst_err_d;
  logic              rst_q, rst_d;

  logic              grant_aw, grant_ar, active, push;
  logic [ADDR_W-1:0] sel_addr;
  logic [LEN_W-1:0]  sel_len;
  logic [2:0]        sel_size, eff_size;
  logic [1:0]        sel_burst, eff_burst;
  logic              size_bad, burst_bad;

  // rst_q keeps both readies low for one cycle after reset releases.
  always_comb begin
    grant_aw = 1'b0;
    grant_ar = 1'b0;
    if (state_q == ST_IDLE && !reset && !rst_q) begin
      grant_aw = bus.awvalid && (!bus.arvalid || !last_grant_q);
      grant_ar = bus.arvalid && !grant_aw;
    end
  end

  always_comb begin
    sel_addr  = grant_aw ? bus.awaddr  : bus.araddr;
    sel_len   = grant_aw ? bus.awlen   : bus.arlen;
    sel_size  = grant_aw ? bus.awsize  : bus.arsize;
    sel_burst = grant_aw ? bus.awburst : bus.arburst;
    size_bad  = sel_size > 3'(BUS_BYTES_LOG2);
    burst_bad = (sel_burst == 2'b11) ||
                (sel_burst == BURST_WRAP && !is_wrap_len(32'(sel_len)));
    eff_size  = size_bad ? 3'(BUS_BYTES_LOG2) : sel_size;
    eff_burst = burst_bad ? BURST_INCR : sel_burst;
  end

  addr_next_calc #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_next (
    .addr      (addr_q),
    .size      (size_q),
    .len       (len_q),
    .burst     (burst_q),
    .next_addr (next_addr)
  );

  assign active = (state_q == ST_BURST) && !reset;
  assign push   = active && !bus.fifo_full;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    len_d        = len_q;
    size_d       = size_q;
    burst_d      = burst_q;
    dir_d        = dir_q;
    beat_cnt_d   = beat_cnt_q;
    last_grant_d = last_grant_q;
    burst_err_d  = 1'b0;
    rst_d        = reset;
    case (state_q)
      ST_IDLE: begin
        if (grant_aw || grant_ar) begin
          state_d      = ST_BURST;
          addr_d       = sel_addr;
          len_d        = sel_len;
          size_d       = eff_size;
          burst_d      = eff_burst;
          dir_d        = grant_aw;
          beat_cnt_d   = sel_len;
          last_grant_d = grant_aw;
          burst_err_d  = size_bad || burst_bad;
        end
      end
      ST_BURST: begin
        if (push) begin
          addr_d = next_addr;
          if (beat_cnt_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q - LEN_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wclk) begin
    rst_q <= rst_d;
    if (reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      len_q        <= '0;
      size_q       <= '0;
      burst_q      <= '0;
      dir_q        <= 1'b0;
      beat_cnt_q   <= '0;
      last_grant_q <= 1'b0;
      burst_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      size_q       <= size_d;
      burst_q      <= burst_d;
      dir_q        <= dir_d;
      beat_cnt_q   <= beat_cnt_d;
      last_grant_q <= last_grant_d;
      burst_err_q  <= burst_err_d;
    end
  end

  always_comb begin
    bus.awready       = grant_aw;
    bus.arready       = grant_ar;
    bus.fifo_write_en = push;
    bus.fifo_data     = active ? addr_q : '0;
    bus.tag_dir       = active && dir_q;
    bus.tag_last      = active && (beat_cnt_q == '0);
    bus.busy          = active;
    bus.burst_err     = burst_err_q && !reset;
  end

endmodule
